// File: rtl/up_pkg.sv
// Shared definitions for the interrupt entry sequencer: datapath op codes
// and the sequencer state encoding.
package up_pkg;

  localparam logic [4:0] OP_NOP     = 5'b00000;
  localparam logic [4:0] OP_ADD_SP  = 5'b11001;
  localparam logic [4:0] OP_WR_PC   = 5'b11011;
  localparam logic [4:0] OP_DEC_SP  = 5'b11010;
  localparam logic [4:0] OP_VEC_JMP = 5'b10000;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_PUSH_ADDR = 3'd1,
    SEQ_PUSH_WR   = 3'd2,
    SEQ_DEC_SP    = 3'd3,
    SEQ_JUMP      = 3'd4
  } seq_state_t;

endpackage

// File: rtl/up_int_prio_enc.sv
// Lowest-index-wins priority encoder: index of the lowest set bit plus a
// valid flag when any bit is set.
module up_int_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/up_int_sequencer.sv
// Interrupt front end and entry sequencer: edge-detected requests, enable mask,
// priority nesting, and the push-PC / dec-SP / vector-jump strobe sequence.
module up_int_sequencer
  import up_pkg::*;
#(
  parameter int N_INT = 4,
  parameter int VEC_W = 3,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [N_INT-1:0] int_req,
  input  logic             int_en_we,
  input  logic [N_INT-1:0] int_en_d,
  input  logic             fetch,
  input  logic             ret,
  input  logic             mem_re,
  output logic             grant,
  output logic             busy,
  output logic             done,
  output logic [OP_W-1:0]  op,
  output logic             pc_we,
  output logic             sp_we,
  output logic             mem_we,
  output logic             ale,
  output logic [VEC_W-1:0] vec,
  output logic [N_INT-1:0] int_pending,
  output logic [N_INT-1:0] int_active,
  output seq_state_t       dbg_state
);

  // Handshakes: fetch/grant -- in IDLE a fetch with an eligible candidate is
  // granted combinationally in the same cycle; mem_we/mem_re -- the PC write
  // is held in PUSH_WR until mem_re is seen high at a clock edge.

  seq_state_t       state, state_nxt;
  logic [N_INT-1:0] int_last, en;
  logic [N_INT-1:0] edges, cand_oh, ret_clr;
  logic [VEC_W-1:0] cand, act_idx;
  logic             cand_valid, act_any, accept;

  up_int_prio_enc #(.N(N_INT), .IW(VEC_W)) u_cand_enc (
    .req   (int_pending & en),
    .idx   (cand),
    .valid (cand_valid)
  );

  up_int_prio_enc #(.N(N_INT), .IW(VEC_W)) u_act_enc (
    .req   (int_active),
    .idx   (act_idx),
    .valid (act_any)
  );

  // Only a strictly higher-priority (lower index) channel may nest.
  assign accept    = (state == SEQ_IDLE) && fetch && cand_valid &&
                     (!act_any || (cand < act_idx));
  assign grant     = accept;
  assign edges     = int_req & ~int_last;
  assign cand_oh   = accept ? (N_INT'(1) << cand) : '0;
  assign ret_clr   = (ret && act_any) ? (N_INT'(1) << act_idx) : '0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= SEQ_IDLE;
      int_last    <= '0;
      int_pending <= '0;
      en          <= '0;
      int_active  <= '0;
      vec         <= '0;
    end else begin
      state       <= state_nxt;
      int_last    <= int_req;
      int_pending <= (int_pending & ~cand_oh) | edges;
      int_active  <= (int_active & ~ret_clr) | cand_oh;
      if (int_en_we) en  <= int_en_d;
      if (accept)    vec <= cand;
    end
  end

  always_comb begin
    state_nxt = state;
    op        = '0;
    busy      = 1'b0;
    done      = 1'b0;
    pc_we     = 1'b0;
    sp_we     = 1'b0;
    mem_we    = 1'b0;
    ale       = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (accept) state_nxt = SEQ_PUSH_ADDR;
      end
      SEQ_PUSH_ADDR: begin
        busy      = 1'b1;
        op        = OP_W'(OP_ADD_SP);
        ale       = 1'b1;
        state_nxt = SEQ_PUSH_WR;
      end
      SEQ_PUSH_WR: begin
        busy   = 1'b1;
        op     = OP_W'(OP_WR_PC);
        mem_we = 1'b1;
        if (mem_re) state_nxt = SEQ_DEC_SP;
      end
      SEQ_DEC_SP: begin
        busy      = 1'b1;
        op        = OP_W'(OP_DEC_SP);
        sp_we     = 1'b1;
        state_nxt = SEQ_JUMP;
      end
      SEQ_JUMP: begin
        busy      = 1'b1;
        op        = OP_W'(OP_VEC_JMP);
        pc_we     = 1'b1;
        done      = 1'b1;
        state_nxt = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_up_int_sequencer.sv
// Bench for up_int_sequencer: directed vectors, a per-cycle behavioural model
// of the interrupt rules, and hand-computed literal checks.
module tb_up_int_sequencer;
  import up_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic [N-1:0] int_req = '0;
  logic         int_en_we = 1'b0;
  logic [N-1:0] int_en_d = '0;
  logic         fetch = 1'b0;
  logic         ret = 1'b0;
  logic         mem_re = 1'b1;
  logic         grant, busy, done, pc_we, sp_we, mem_we, ale;
  logic [4:0]   op;
  logic [2:0]   vec;
  logic [N-1:0] int_pending, int_active;
  seq_state_t   dbg_state;

  int total = 0;
  int bad   = 0;

  up_int_sequencer #(.N_INT(N), .VEC_W(3), .OP_W(5)) dut (
    .clk(clk), .nRst(nRst), .int_req(int_req), .int_en_we(int_en_we),
    .int_en_d(int_en_d), .fetch(fetch), .ret(ret), .mem_re(mem_re),
    .grant(grant), .busy(busy), .done(done), .op(op), .pc_we(pc_we),
    .sp_we(sp_we), .mem_we(mem_we), .ale(ale), .vec(vec),
    .int_pending(int_pending), .int_active(int_active), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  bit m_pend[N], m_en[N], m_act[N], m_last[N];
  int m_vec  = 0;
  int m_step = 0;  // 0 = no entry in progress, 1..4 = entry step number

  function automatic int lowest_eligible();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic int lowest_active();
    for (int i = 0; i < N; i++) if (m_act[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] pack(input bit a[N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  // compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    int c, a;
    logic e_grant, e_ale, e_mwe, e_swe, e_pwe, e_done;
    logic [4:0] e_op;
    if (!nRst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_act[i] = 0; m_last[i] = 0;
      end
      m_vec = 0;
      m_step = 0;
    end
    c = lowest_eligible();
    a = lowest_active();
    e_grant = (m_step == 0) && fetch && (c >= 0) && (a < 0 || c < a);
    e_op = 5'b00000; e_ale = 0; e_mwe = 0; e_swe = 0; e_pwe = 0; e_done = 0;
    case (m_step)
      1: begin e_op = 5'b11001; e_ale = 1; end
      2: begin e_op = 5'b11011; e_mwe = 1; end
      3: begin e_op = 5'b11010; e_swe = 1; end
      4: begin e_op = 5'b10000; e_pwe = 1; e_done = 1; end
      default: ;
    endcase
    chk("m_grant",   grant,       e_grant);
    chk("m_busy",    busy,        m_step != 0);
    chk("m_op",      op,          e_op);
    chk("m_ale",     ale,         e_ale);
    chk("m_mem_we",  mem_we,      e_mwe);
    chk("m_sp_we",   sp_we,       e_swe);
    chk("m_pc_we",   pc_we,       e_pwe);
    chk("m_done",    done,        e_done);
    chk("m_vec",     vec,         m_vec);
    chk("m_pending", int_pending, pack(m_pend));
    chk("m_active",  int_active,  pack(m_act));
    if (nRst) begin
      // state after the coming rising edge
      if (ret && a >= 0) m_act[a] = 0;
      if (e_grant) begin
        m_pend[c] = 0;
        m_act[c]  = 1;
        m_vec     = c;
      end
      for (int i = 0; i < N; i++) begin
        if (int_req[i] && !m_last[i]) m_pend[i] = 1;
        m_last[i] = int_req[i];
        if (int_en_we) m_en[i] = int_en_d[i];
      end
      if (m_step == 0) m_step = e_grant ? 1 : 0;
      else if (m_step == 2 && !mem_re) m_step = 2;
      else if (m_step == 4) m_step = 0;
      else m_step = m_step + 1;
    end
  end

  // driver tasks
  task automatic load_en(input logic [N-1:0] m);
    int_en_we = 1'b1; int_en_d = m;
    tick();
    int_en_we = 1'b0;
  endtask

  task automatic pulse_ret();
    ret = 1'b1;
    tick();
    ret = 1'b0;
  endtask

  task automatic accept_and_run();
    fetch = 1'b1;
    #1 chk("grant", grant, 1'b1);
    tick();
    fetch = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int n_we, n_sp, done_c;

    // reset release and single channel 0 entry
    repeat (2) tick();
    nRst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_op", op, 5'b0);
    chk("rst_pending", int_pending, 4'b0000);
    chk("rst_active", int_active, 4'b0000);
    chk("rst_vec", vec, 3'd0);
    load_en(4'b0001);
    int_req = 4'b0001;
    tick();
    int_req = 4'b0000;
    chk("t1_pending", int_pending, 4'b0001);
    fetch = 1'b1;
    #1 chk("t1_grant", grant, 1'b1);
    tick();
    fetch = 1'b0;
    chk("t1_op_push_addr", op, 5'b11001);
    chk("t1_ale", ale, 1'b1);
    tick();
    chk("t1_op_push_wr", op, 5'b11011);
    tick();
    chk("t1_op_dec_sp", op, 5'b11010);
    tick();
    chk("t1_op_jump", op, 5'b10000);
    chk("t1_done", done, 1'b1);
    chk("t1_vec", vec, 3'd0);
    chk("t1_active", int_active, 4'b0001);
    tick();
    chk("t1_idle_busy", busy, 1'b0);
    pulse_ret();

    // masked channel 2 held pending until enabled
    load_en(4'b0000);
    int_req = 4'b0100;
    tick();
    fetch = 1'b1;
    #1 chk("t2_masked_grant", grant, 1'b0);
    chk("t2_pending", int_pending, 4'b0100);
    tick();
    int_en_we = 1'b1; int_en_d = 4'b0100;
    #1 chk("t2_enable_cycle_grant", grant, 1'b0);
    tick();
    int_en_we = 1'b0;
    accept_and_run();
    chk("t2_vec", vec, 3'd2);
    chk("t2_active", int_active, 4'b0100);
    int_req = 4'b0000;
    pulse_ret();

    // channels 1 and 3 together: 1 first, 3 waits for ret
    load_en(4'b1111);
    int_req = 4'b1010;
    tick();
    int_req = 4'b0000;
    accept_and_run();
    chk("t3_vec1", vec, 3'd1);
    chk("t3_pending3", int_pending, 4'b1000);
    fetch = 1'b1; ret = 1'b1;
    #1 chk("t3_no_preempt", grant, 1'b0);
    tick();
    ret = 1'b0;
    accept_and_run();
    chk("t3_vec3", vec, 3'd3);
    pulse_ret();

    // nesting: channel 0 over active channel 2
    int_req = 4'b0100;
    tick();
    int_req = 4'b0000;
    accept_and_run();
    int_req = 4'b0001;
    tick();
    int_req = 4'b0000;
    accept_and_run();
    chk("t4_nested_active", int_active, 4'b0101);
    pulse_ret();
    chk("t4_ret_first", int_active, 4'b0100);
    pulse_ret();
    chk("t4_ret_second", int_active, 4'b0000);

    // memory stall in PUSH_WR
    int_req = 4'b0010;
    tick();
    int_req = 4'b0000;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    n_we = 0; n_sp = 0; done_c = 0;
    for (int c = 1; c <= 8; c++) begin
      mem_re = (c >= 5);
      #1;
      if (mem_we) n_we++;
      if (sp_we) n_sp++;
      if (done) done_c = c;
      tick();
    end
    mem_re = 1'b1;
    chk("t5_mem_we_cycles", n_we, 4);
    chk("t5_sp_we_cycles", n_sp, 1);
    chk("t5_done_offset", done_c, 7);
    pulse_ret();

    // reset during DEC_SP
    int_req = 4'b0110;
    tick();
    int_req = 4'b0000;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    tick();
    chk("t6_in_dec_sp", sp_we, 1'b1);
    nRst = 1'b0;
    #1;
    chk("t6_rst_sp_we", sp_we, 1'b0);
    chk("t6_rst_op", op, 5'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_vec", vec, 3'd0);
    chk("t6_rst_active", int_active, 4'b0000);
    tick();
    tick();
    nRst = 1'b1;
    chk("t6_rel_pending", int_pending, 4'b0000);
    int_req = 4'b0001;
    tick();
    int_req = 4'b0000;
    fetch = 1'b1;
    #1 chk("t6_en_cleared_grant", grant, 1'b0);
    chk("t6_pending_after", int_pending, 4'b0001);
    tick();
    fetch = 1'b0;
    repeat (3) tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
